// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - SHA-256 message fetch and padding feeder, one 512-bit block at a time
module sha256_msg_padder #(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [15:0]  message_addr,
    output logic         mem_clk,
    output logic [15:0]  mem_addr,
    input  logic [31:0]  mem_read_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_last,
    output logic         busy,
    output logic         done
);

    localparam int          NUM_BLOCKS = (NUM_OF_WORDS + 2) / 16 + 1;
    localparam logic [15:0] N16        = 16'(NUM_OF_WORDS);
    localparam logic [15:0] LAST_OFS   = 16'(NUM_OF_WORDS - 1);
    localparam logic [31:0] BIT_LEN    = 32'(NUM_OF_WORDS * 32);
    localparam logic [5:0]  LAST_BLK   = 6'(NUM_BLOCKS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t       state;
    logic [15:0]  base;
    logic [5:0]   blk_idx;
    logic [4:0]   cycle;
    logic [479:0] asm_q;
    logic [3:0]   cap_slot;
    logic [15:0]  cap_g;
    logic [31:0]  cap_word;

    assign mem_clk = clk;
    assign busy    = (state != IDLE);

    // Words past the end of the message keep re-addressing the final word.
    function automatic logic [15:0] rd_addr(input logic [15:0] b, input logic [5:0] blk,
                                            input logic [4:0] s);
        logic [15:0] g;
        g = {6'd0, blk, 4'd0} + {11'd0, s};
        return b + ((g < N16) ? g : LAST_OFS);
    endfunction

    // Data for slot cycle-1 arrives now, one cycle after its address was issued.
    always_comb begin
        cap_slot = 4'(cycle - 5'd1);
        cap_g    = {6'd0, blk_idx, 4'd0} + {12'd0, cap_slot};
        cap_word = 32'd0;
        if (cap_g < N16)
            cap_word = mem_read_data;
        else if (cap_g == N16)
            cap_word = 32'h8000_0000;
        else if ((blk_idx == LAST_BLK) && (cap_slot == 4'd15))
            cap_word = BIT_LEN;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            base      <= 16'd0;
            blk_idx   <= 6'd0;
            cycle     <= 5'd0;
            asm_q     <= '0;
            mem_addr  <= 16'd0;
            blk_valid <= 1'b0;
            blk_data  <= '0;
            blk_first <= 1'b0;
            blk_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base     <= message_addr;
                        blk_idx  <= 6'd0;
                        cycle    <= 5'd0;
                        mem_addr <= message_addr;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if ((cycle != 5'd0) && (cycle != 5'd16))
                        asm_q[479 - 32 * int'(cap_slot) -: 32] <= cap_word;
                    if (cycle < 5'd15)
                        mem_addr <= rd_addr(base, blk_idx, 5'(cycle + 5'd1));
                    if (cycle == 5'd16) begin
                        blk_data  <= {asm_q, cap_word};
                        blk_valid <= 1'b1;
                        blk_first <= (blk_idx == 6'd0);
                        blk_last  <= (blk_idx == LAST_BLK);
                        state     <= HOLD;
                    end else begin
                        cycle <= 5'(cycle + 5'd1);
                    end
                end
                HOLD: begin
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        if (blk_idx == LAST_BLK) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            blk_idx  <= 6'(blk_idx + 6'd1);
                            cycle    <= 5'd0;
                            mem_addr <= rd_addr(base, 6'(blk_idx + 6'd1), 5'd0);
                            state    <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
